// File: rtl/dnn_fp_pkg.sv
// -----------------------------------------------------------------------------
// dnn_fp_pkg
// Shared constants and types for the mantissa divider (div11x11, div_step).
//   MANT_W    : stored mantissa fraction width (hidden bit implied)
//   DIV_Q_W   : quotient width
//   DIV_ITERS : restoring iterations, one quotient bit each
//   DIV_REM_W : partial remainder width
//   DIV_RES_W : result width {quotient, sticky}
//   DIV_CNT_W : step counter width
// -----------------------------------------------------------------------------
package dnn_fp_pkg;

    localparam int MANT_W    = 10;
    localparam int DIV_Q_W   = 12;
    localparam int DIV_ITERS = 12;
    localparam int DIV_REM_W = 13;
    localparam int DIV_RES_W = DIV_Q_W + 1;
    localparam int DIV_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step: shift the partial remainder left
// by one (bringing in bit_i), trial-subtract the divisor {1,div_frac_i}, keep
// the difference when it is non-negative.
// Ports:
//   rem_i      : partial remainder before the step
//   bit_i      : dividend bit shifted into the remainder LSB
//   div_frac_i : divisor fraction (hidden 1 prepended here)
//   rem_o      : partial remainder after the step
//   q_o        : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import dnn_fp_pkg::*;
(
    input  logic [DIV_REM_W-1:0] rem_i,
    input  logic                 bit_i,
    input  logic [MANT_W-1:0]    div_frac_i,
    output logic [DIV_REM_W-1:0] rem_o,
    output logic                 q_o
);

    logic [DIV_REM_W:0]   shifted;
    logic [DIV_REM_W-1:0] divisor;
    logic [DIV_REM_W-1:0] diff;

    assign shifted = {rem_i, bit_i};
    assign divisor = {{(DIV_REM_W-MANT_W-1){1'b0}}, 1'b1, div_frac_i};

    // Comparing at full shifted width gives the sign of the trial subtraction.
    assign q_o = (shifted >= {1'b0, divisor});

    // When the subtraction is kept the true difference is below the divisor,
    // so the truncated-width subtract is exact.
    assign diff  = shifted[DIV_REM_W-1:0] - divisor;
    assign rem_o = q_o ? diff : shifted[DIV_REM_W-1:0];

endmodule

// File: rtl/div11x11.sv
// -----------------------------------------------------------------------------
// div11x11
// Sequential restoring divider for 11-bit mantissas with hidden bit:
//   Q = floor(({1,f1} << 11) / {1,f2}), 12 bits, result = {Q, sticky}.
// Timing: st sampled in IDLE at edge N; first CALC cycle aligns the dividend
// into the remainder, the next 12 CALC cycles each produce one quotient bit
// (MSB first), FIN publishes the result. done pulses in the cycle after edge
// N+14; with st held high a new operation starts every 15 cycles.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset, aborts any operation
//   st     : start request, only looked at in IDLE
//   f1, f2 : dividend / divisor fractions, latched at start
//   busy   : high in CALC and FIN
//   done   : one-cycle completion pulse
//   result : {quotient[11:0], sticky}, held until the next done or reset
// Build option: define DIV11X11_STICKY_EN to make result[0] report a non-zero
// final remainder; otherwise result[0] is 0 and no remainder test exists.
// -----------------------------------------------------------------------------
module div11x11
    import dnn_fp_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 st,
    input  logic [MANT_W-1:0]    f1,
    input  logic [MANT_W-1:0]    f2,
    output logic                 busy,
    output logic                 done,
    output logic [DIV_RES_W-1:0] result
);

    localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(DIV_ITERS);

    div_state_t             state_q,  state_d;
    logic [DIV_CNT_W-1:0]   cnt_q,    cnt_d;
    logic [MANT_W-1:0]      f1_q,     f1_d;
    logic [MANT_W-1:0]      f2_q,     f2_d;
    logic [DIV_REM_W-1:0]   rem_q,    rem_d;
    logic [DIV_Q_W-1:0]     quo_q,    quo_d;
    logic [DIV_RES_W-1:0]   result_q, result_d;
    logic                   done_q,   done_d;

    logic [DIV_REM_W-1:0]   step_rem;
    logic                   step_q;
    logic                   step_bit;
    logic                   sticky;

    // The aligned remainder holds {1,f1} >> 1; the dropped LSB of the dividend
    // enters on the first real step, zeros on all later ones.
    assign step_bit = (cnt_q == DIV_CNT_W'(1)) ? f1_q[0] : 1'b0;

    div_step u_step (
        .rem_i      (rem_q),
        .bit_i      (step_bit),
        .div_frac_i (f2_q),
        .rem_o      (step_rem),
        .q_o        (step_q)
    );

`ifdef DIV11X11_STICKY_EN
    assign sticky = |rem_q;
`else
    assign sticky = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f1_d     = f1_q;
        f2_d     = f2_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (st) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    f1_d    = f1;
                    f2_d    = f2;
                    rem_d   = '0;
                    quo_d   = '0;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    rem_d = {{(DIV_REM_W-MANT_W){1'b0}}, 1'b1, f1_q[MANT_W-1:1]};
                    cnt_d = DIV_CNT_W'(1);
                end else begin
                    rem_d = step_rem;
                    quo_d = {quo_q[DIV_Q_W-2:0], step_q};
                    if (cnt_q == LAST_STEP) begin
                        state_d = FIN;
                    end else begin
                        cnt_d = cnt_q + DIV_CNT_W'(1);
                    end
                end
            end
            FIN: begin
                state_d  = IDLE;
                cnt_d    = '0;
                result_d = {quo_q, sticky};
                done_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f1_q     <= '0;
            f2_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f1_q     <= f1_d;
            f2_q     <= f2_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == CALC) || (state_q == FIN);
    assign done   = done_q;
    assign result = result_q;

endmodule
